// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared decode types and MMIO register map for data_memory_mmio
package dmem_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_OOR
  } region_e;

  localparam logic [11:0] OFF_LED    = 12'h000;
  localparam logic [11:0] OFF_SW     = 12'h004;
  localparam logic [11:0] OFF_CYCLE  = 12'h008;
  localparam logic [11:0] OFF_STORES = 12'h00C;
  localparam logic [11:0] OFF_STATUS = 12'h010;

  localparam int ST_MISALIGN = 0;
  localparam int ST_OOR      = 1;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterised two-flop synchronizer
module sync2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/data_memory_mmio.sv
// rtl/data_memory_mmio.sv - data RAM plus MMIO page on the datapath memory port
module data_memory_mmio
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned SW_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             err_irq
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  region_e          region;
  logic             aligned;
  logic             ram_we;
  logic             mmio_we;
  logic [11:0]      mmio_off;
  logic [AW-1:0]    ram_idx;
  logic [SW_W-1:0]  sw_sync;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      stores_q, stores_d;
  logic [1:0]       status_q, status_d;
  logic [1:0]       st_set, st_clr;
  logic             err_q;

  assign aligned  = (Addr[1:0] == 2'b00);
  assign mmio_off = {Addr[11:2], 2'b00};
  assign ram_idx  = Addr[AW+1:2];

  always_comb begin
    region = REG_OOR;
    if (Addr[31:12] == MMIO_BASE[31:12]) begin
      region = REG_MMIO;
    end else if (Addr < RAM_BYTES) begin
      region = REG_RAM;
    end
  end

  // Enables derive from the decode, so an unknown address never reaches the array.
  assign ram_we  = rst_n && MemWrite && aligned && (region == REG_RAM);
  assign mmio_we = MemWrite && aligned && (region == REG_MMIO);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= WriteData;
    end
  end

  sync2 #(.W(SW_W)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sw_in),
    .q_o   (sw_sync)
  );

  always_comb begin
    led_d    = led_q;
    cycle_d  = cycle_q + 32'd1;
    stores_d = stores_q;
    st_set   = '0;
    st_clr   = '0;
    if (mmio_we && (mmio_off == OFF_LED)) led_d = WriteData[LED_W-1:0];
    if (mmio_we && (mmio_off == OFF_STATUS)) st_clr = WriteData[1:0];
    if (ram_we && (stores_q != '1)) stores_d = stores_q + 32'd1;
    if (MemWrite && !aligned) st_set[ST_MISALIGN] = 1'b1;
    if (MemWrite && (region == REG_OOR)) st_set[ST_OOR] = 1'b1;
    // A new error on the same edge as its clear must survive.
    status_d = (status_q & ~st_clr) | st_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      cycle_q  <= '0;
      stores_q <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      status_q <= status_d;
      err_q    <= |status_d;
    end
  end

  assign led_out = led_q;
  assign err_irq = err_q;

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM:  ReadData = mem_q[ram_idx];
      REG_MMIO: begin
        case (mmio_off)
          OFF_LED:    ReadData = 32'(led_q);
          OFF_SW:     ReadData = 32'(sw_sync);
          OFF_CYCLE:  ReadData = cycle_q;
          OFF_STORES: ReadData = stores_q;
          OFF_STATUS: ReadData = {30'b0, status_q};
          default:    ReadData = '0;
        endcase
      end
      default:  ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// tb/tb_data_memory_mmio.sv - self-checking bench for data_memory_mmio
module tb_data_memory_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic        err_irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem_m [64];
  bit          mem_v [64];
  logic [7:0]  led_m, sw1_m, sw2_m;
  logic [31:0] cyc_m, sto_m;
  logic [1:0]  st_m;

  always #5 clk = ~clk;

  data_memory_mmio dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .err_irq   (err_irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    if (a[31:12] == 20'h00001) return 1;
    if (a < 32'd256) return 0;
    return 2;
  endfunction

  function automatic logic [32:0] exp_rd(input logic [31:0] a);
    logic [11:0] off;
    off = {a[11:2], 2'b00};
    case (region_of(a))
      0: return {mem_v[a[7:2]], mem_m[a[7:2]]};
      1: begin
        case (off)
          12'h000: return {1'b1, 24'b0, led_m};
          12'h004: return {1'b1, 24'b0, sw2_m};
          12'h008: return {1'b1, cyc_m};
          12'h00C: return {1'b1, sto_m};
          12'h010: return {1'b1, 30'b0, st_m};
          default: return {1'b1, 32'b0};
        endcase
      end
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  task automatic model_reset;
    led_m = '0;
    sw1_m = '0;
    sw2_m = '0;
    cyc_m = '0;
    sto_m = '0;
    st_m  = '0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      logic [1:0] s_bits, c_bits;
      int r;
      s_bits = '0;
      c_bits = '0;
      if (MemWrite === 1'b1) begin
        r = region_of(Addr);
        if (Addr[1:0] != 2'b00) s_bits[0] = 1'b1;
        if (r == 2) s_bits[1] = 1'b1;
        if (Addr[1:0] == 2'b00) begin
          if (r == 0) begin
            mem_m[Addr[7:2]] = WriteData;
            mem_v[Addr[7:2]] = 1'b1;
            if (sto_m != 32'hFFFF_FFFF) sto_m = sto_m + 1;
          end else if (r == 1) begin
            if (Addr[11:0] == 12'h000) led_m = WriteData[7:0];
            if (Addr[11:0] == 12'h010) c_bits = WriteData[1:0];
          end
        end
      end
      st_m  = (st_m & ~c_bits) | s_bits;
      sw2_m = sw1_m;
      sw1_m = sw_in;
      cyc_m = cyc_m + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [32:0] e;
      e = exp_rd(Addr);
      if (e[32]) chk("rd_model", ReadData, e[31:0]);
      chk("led_model", 32'(led_out), 32'(led_m));
      chk("irq_model", 32'(err_irq), 32'(st_m != 2'b00));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    Addr = a;
    #1;
    chk(nm, ReadData, e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0; sw_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rd("rst_cycle", 32'h1008, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_irq", 32'(err_irq), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    rd("cycle3", 32'h1008, 32'd3);
    chk("led0", 32'(led_out), 32'd0);
    chk("irq0", 32'(err_irq), 32'd0);

    wr(32'h18, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h18, 32'hDEAD_BEEF);
    rd("stores1", 32'h100C, 32'd1);

    wr(32'h1A, 32'h1234_5678);
    rd("mis_keep", 32'h18, 32'hDEAD_BEEF);
    rd("status_mis", 32'h1010, 32'd1);
    chk("irq_mis", 32'(err_irq), 32'd1);
    rd("stores_hold", 32'h100C, 32'd1);
    wr(32'h1010, 32'h1);
    rd("status_w1c", 32'h1010, 32'd0);
    chk("irq_clr", 32'(err_irq), 32'd0);

    wr(32'h800, 32'h55);
    rd("status_oor", 32'h1010, 32'd2);
    rd("oor_rd", 32'h800, 32'd0);
    chk("irq_oor", 32'(err_irq), 32'd1);
    wr(32'h1010, 32'h2);
    rd("status_oor_clr", 32'h1010, 32'd0);

    sw_in = 8'hA5;
    Addr  = 32'h1004;
    step();
    rd("sw_1edge", 32'h1004, 32'd0);
    step();
    rd("sw_2edge", 32'h1004, 32'h0000_00A5);

    wr(32'h1000, 32'h13C);
    chk("led_out", 32'(led_out), 32'h3C);
    rd("led_rd", 32'h1000, 32'h3C);

    wr(32'h6, 32'h1);
    wr(32'h1012, 32'h1);
    rd("set_wins", 32'h1010, 32'd1);
    rd("stores7", 32'h100C, 32'd1);
    wr(32'h1010, 32'h3);
    rd("status_clr_all", 32'h1010, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (i == 2000) rst_n = 1'b0;
      if (i == 2003) rst_n = 1'b1;
      MemWrite  = ($urandom_range(0, 2) == 0);
      WriteData = $urandom;
      if (k < 45)      Addr = 32'($urandom_range(0, 63)) << 2;
      else if (k < 55) Addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (k < 85) Addr = 32'h1000 + (32'($urandom_range(0, 7)) << 2)
                              + (($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0);
      else if (k < 95) Addr = 32'h100 + 32'($urandom_range(0, 32'hEFF));
      else             Addr = $urandom;
      if ($urandom_range(0, 7) == 0) sw_in = 8'($urandom);
      step();
    end
    MemWrite = 1'b0;
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
